// File: rtl/duc_cfg_pkg.sv
// Shared types, constants and the enable-to-group mapping for the DUC
// configuration scheduler.
package duc_cfg_pkg;

  localparam int NUM_GRP     = 36;
  localparam int FW_W        = 10;
  localparam int NUM_ENA     = 72;
  localparam int CH_PER_BANK = 24;

  localparam logic [6:0] FW_BASE  = 7'h00;
  localparam logic [6:0] ENA_BASE = 7'h40;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_MUTE   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_UNMUTE = 3'd4
  } cfg_state_t;

  // Two adjacent channels of a bank share one NCO group.
  function automatic int unsigned grp_of(input int unsigned e);
    return (e / 32'd24) * 32'd12 + (e % 32'd24) / 32'd2;
  endfunction

endpackage

// File: rtl/duc_cfg_shadow.sv
// Host-facing shadow register file: address decode, shadow frequency words
// and enables, and the write-reject pulse.
module duc_cfg_shadow #(
  parameter int NUM_GRP = duc_cfg_pkg::NUM_GRP,
  parameter int FW_W    = duc_cfg_pkg::FW_W,
  parameter int NUM_ENA = duc_cfg_pkg::NUM_ENA
) (
  input  logic                    clk_1,
  input  logic                    rst,
  input  logic                    ce_1,
  input  logic                    wr_en,
  input  logic [6:0]              wr_addr,
  input  logic [15:0]             wr_data,
  input  logic                    busy,
  output logic [NUM_GRP*FW_W-1:0] shadow_fw,
  output logic [NUM_ENA-1:0]      shadow_ena,
  output logic                    wr_err
);
  import duc_cfg_pkg::*;

  localparam int NUM_BANK = NUM_ENA / CH_PER_BANK;

  logic [6:0]              fw_off_s;
  logic [6:0]              ena_off_s;
  logic                    addr_hit_s;
  logic [NUM_GRP*FW_W-1:0] shadow_fw_r;
  logic [NUM_ENA-1:0]      shadow_ena_r;
  logic                    wr_err_r;

  // Address decode; offsets below a base wrap high and so never match.
  always_comb begin
    fw_off_s   = wr_addr - FW_BASE;
    ena_off_s  = wr_addr - ENA_BASE;
    addr_hit_s = (fw_off_s < 7'(NUM_GRP)) || (ena_off_s < 7'(2 * NUM_BANK));
  end

  // Shadow registers and the one-cycle reject pulse.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      shadow_fw_r  <= '0;
      shadow_ena_r <= '0;
      wr_err_r     <= 1'b0;
    end else if (ce_1) begin
      wr_err_r <= wr_en & (busy | ~addr_hit_s);
      if (wr_en && !busy) begin
        for (int k = 0; k < NUM_GRP; k++) begin
          if (fw_off_s == 7'(k)) shadow_fw_r[k*FW_W +: FW_W] <= wr_data[FW_W-1:0];
        end
        for (int b = 0; b < NUM_BANK; b++) begin
          if (ena_off_s == 7'(2 * b))     shadow_ena_r[b*CH_PER_BANK +: 16]      <= wr_data;
          if (ena_off_s == 7'(2 * b + 1)) shadow_ena_r[b*CH_PER_BANK + 16 +: 8]  <= wr_data[7:0];
        end
      end
    end
  end

  assign shadow_fw  = shadow_fw_r;
  assign shadow_ena = shadow_ena_r;
  assign wr_err     = wr_err_r;

endmodule

// File: rtl/duc_cfg_sched.sv
// Frame-aligned configuration scheduler: mutes retuned channels, swaps the
// NCO words after a mute interval, then restores the shadow enables.
module duc_cfg_sched #(
  parameter int NUM_GRP  = duc_cfg_pkg::NUM_GRP,
  parameter int FW_W     = duc_cfg_pkg::FW_W,
  parameter int NUM_ENA  = duc_cfg_pkg::NUM_ENA,
  parameter int MUTE_CYC = 4
) (
  input  logic                    clk_1,
  input  logic                    rst,
  input  logic                    ce_1,
  input  logic                    wr_en,
  input  logic [6:0]              wr_addr,
  input  logic [15:0]             wr_data,
  input  logic                    commit_req,
  input  logic                    frame_sync,
  output logic                    commit_busy,
  output logic                    commit_done,
  output logic                    wr_err,
  output logic [NUM_GRP*FW_W-1:0] freq_word,
  output logic [NUM_ENA-1:0]      ena
);
  import duc_cfg_pkg::*;

  logic [NUM_GRP*FW_W-1:0] shadow_fw_s;
  logic [NUM_ENA-1:0]      shadow_ena_s;
  logic [NUM_GRP-1:0]      chg_s;
  logic [NUM_ENA-1:0]      keep_s;

  cfg_state_t              state_r;
  logic [3:0]              cnt_r;
  logic                    busy_r;
  logic                    done_r;
  logic [NUM_GRP*FW_W-1:0] fw_r;
  logic [NUM_ENA-1:0]      ena_r;

  duc_cfg_shadow #(
    .NUM_GRP (NUM_GRP),
    .FW_W    (FW_W),
    .NUM_ENA (NUM_ENA)
  ) u_shadow (
    .clk_1      (clk_1),
    .rst        (rst),
    .ce_1       (ce_1),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy_r),
    .shadow_fw  (shadow_fw_s),
    .shadow_ena (shadow_ena_s),
    .wr_err     (wr_err)
  );

  // Change mask and the enables that may stay live through the mute window.
  always_comb begin
    chg_s  = '0;
    keep_s = '0;
    for (int k = 0; k < NUM_GRP; k++) begin
      chg_s[k] = (shadow_fw_s[k*FW_W +: FW_W] != fw_r[k*FW_W +: FW_W]);
    end
    for (int e = 0; e < NUM_ENA; e++) begin
      keep_s[e] = shadow_ena_s[e] & ~chg_s[grp_of(e)];
    end
  end

  // Commit sequencer with registered busy/done, words and enables.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fw_r    <= '0;
      ena_r   <= '0;
    end else if (ce_1) begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (commit_req) begin
            busy_r  <= 1'b1;
            state_r <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (frame_sync) begin
            ena_r <= ena_r & keep_s;
            cnt_r <= 4'(MUTE_CYC - 1);
            // A single-cycle mute has no countdown to spend in MUTE.
            if (MUTE_CYC == 1) state_r <= ST_LOAD;
            else               state_r <= ST_MUTE;
          end
        end
        ST_MUTE: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r <= 4'd1) state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          fw_r    <= shadow_fw_s;
          state_r <= ST_UNMUTE;
        end
        ST_UNMUTE: begin
          ena_r   <= shadow_ena_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign commit_busy = busy_r;
  assign commit_done = done_r;
  assign freq_word   = fw_r;
  assign ena         = ena_r;

endmodule

// File: tb/tb_duc_cfg_sched.sv
// Directed bench for duc_cfg_sched: commit timing, mute masking, write
// rejection, same-cycle commit/sync, async reset and clock-enable freeze.
module tb_duc_cfg_sched;
  localparam int NG  = 36;
  localparam int FW  = 10;
  localparam int NE  = 72;
  localparam int FWV = NG * FW;

  typedef logic [FWV-1:0] vec_t;

  logic          clk_1 = 1'b0;
  logic          rst, ce_1, wr_en, commit_req, frame_sync;
  logic [6:0]    wr_addr;
  logic [15:0]   wr_data;
  logic          commit_busy, commit_done, wr_err;
  logic [FWV-1:0] freq_word;
  logic [NE-1:0]  ena;

  logic [FWV-1:0] fw_model, fw_exp;
  logic [NE-1:0]  ena_model;
  int tests_run    = 0;
  int tests_failed = 0;

  duc_cfg_sched #(.NUM_GRP(NG), .FW_W(FW), .NUM_ENA(NE), .MUTE_CYC(4)) dut (
    .clk_1(clk_1), .rst(rst), .ce_1(ce_1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit_req(commit_req), .frame_sync(frame_sync),
    .commit_busy(commit_busy), .commit_done(commit_done), .wr_err(wr_err),
    .freq_word(freq_word), .ena(ena)
  );

  always #5 clk_1 = ~clk_1;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic host_write(input logic [6:0] a, input logic [15:0] d, input logic exp_err);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    check("wr_err", vec_t'(wr_err), vec_t'(exp_err));
  endtask

  task automatic do_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    check("busy_set", vec_t'(commit_busy), vec_t'(1'b1));
  endtask

  // Sync at edge s; cycle n below is the value seen after edge s+n-1.
  task automatic apply_check(input logic [FWV-1:0] fw_new, input logic [NE-1:0] ena_mid,
                             input logic [NE-1:0] ena_new);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (n > 1) tick();
      check("ena_mute", vec_t'(ena), vec_t'(ena_mid));
      check("busy_mute", vec_t'(commit_busy), vec_t'(1'b1));
      if (n == 4) check("fw_hold", freq_word, fw_model);
    end
    check("fw_swap", freq_word, fw_new);
    tick();
    check("ena_restore", vec_t'(ena), vec_t'(ena_new));
    check("done_pulse", vec_t'(commit_done), vec_t'(1'b1));
    check("busy_clear", vec_t'(commit_busy), vec_t'(1'b0));
    tick();
    check("done_clear", vec_t'(commit_done), vec_t'(1'b0));
    fw_model  = fw_new;
    ena_model = ena_new;
  endtask

  initial begin
    rst = 1'b1; ce_1 = 1'b1; wr_en = 1'b0; wr_addr = 7'd0; wr_data = 16'd0;
    commit_req = 1'b0; frame_sync = 1'b0;
    fw_model = '0; ena_model = '0;
    tick(); tick();
    check("rst_fw", freq_word, vec_t'(0));
    check("rst_ena", vec_t'(ena), vec_t'(0));
    check("rst_busy", vec_t'(commit_busy), vec_t'(1'b0));
    check("rst_done", vec_t'(commit_done), vec_t'(1'b0));
    check("rst_err", vec_t'(wr_err), vec_t'(1'b0));
    rst = 1'b0;
    tick();

    // Basic commit: upper data bits of a frequency write are ignored.
    host_write(7'h05, 16'hFD55, 1'b0);
    host_write(7'h40, 16'hFFFF, 1'b0);
    do_commit();
    tick(); tick();
    check("armed_wait", vec_t'(commit_busy), vec_t'(1'b1));
    fw_exp = fw_model; fw_exp[5*FW +: FW] = 10'h155;
    apply_check(fw_exp, 72'h0, 72'h0000_FFFF);

    // Retune group 0, drop channel 15, newly enable bank 1 channels 0-1.
    host_write(7'h00, 16'h0010, 1'b0);
    host_write(7'h40, 16'h7FFF, 1'b0);
    host_write(7'h42, 16'h0003, 1'b0);
    do_commit();
    fw_exp = fw_model; fw_exp[0 +: FW] = 10'h010;
    apply_check(fw_exp, 72'h0000_7FFC, 72'h0300_7FFF);

    host_write(7'h00, 16'h0020, 1'b0);
    do_commit();
    fw_exp = fw_model; fw_exp[0 +: FW] = 10'h020;
    apply_check(fw_exp, 72'h0300_7FFC, 72'h0300_7FFF);

    // Rejected writes: unmapped addresses and any write while busy.
    host_write(7'h30, 16'h1234, 1'b1);
    tick();
    check("err_clear", vec_t'(wr_err), vec_t'(1'b0));
    host_write(7'h24, 16'h03FF, 1'b1);
    host_write(7'h46, 16'hFFFF, 1'b1);
    check("err_fw_same", freq_word, fw_model);
    check("err_ena_same", vec_t'(ena), vec_t'(ena_model));
    do_commit();
    host_write(7'h00, 16'h03FF, 1'b1);
    host_write(7'h40, 16'h0000, 1'b1);
    apply_check(fw_model, ena_model, ena_model);

    // Commit and sync together: only the request is taken.
    host_write(7'h01, 16'h00AB, 1'b0);
    commit_req = 1'b1; frame_sync = 1'b1;
    tick();
    commit_req = 1'b0; frame_sync = 1'b0;
    check("same_busy", vec_t'(commit_busy), vec_t'(1'b1));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("same_no_mute", vec_t'(ena), vec_t'(ena_model));
      check("same_no_done", vec_t'(commit_done), vec_t'(1'b0));
    end
    fw_exp = fw_model; fw_exp[1*FW +: FW] = 10'h0AB;
    apply_check(fw_exp, 72'h0300_7FF3, 72'h0300_7FFF);

    // Asynchronous reset in the middle of the mute window.
    host_write(7'h02, 16'h0111, 1'b0);
    do_commit();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    tick();
    check("pre_rst_mute", vec_t'(ena), vec_t'(72'h0300_7FCF));
    #2 rst = 1'b1;
    #1;
    check("arst_fw", freq_word, vec_t'(0));
    check("arst_ena", vec_t'(ena), vec_t'(0));
    check("arst_busy", vec_t'(commit_busy), vec_t'(1'b0));
    tick();
    rst = 1'b0;
    fw_model = '0; ena_model = '0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("post_rst_busy", vec_t'(commit_busy), vec_t'(1'b0));
    check("post_rst_done", vec_t'(commit_done), vec_t'(1'b0));
    check("post_rst_fw", freq_word, vec_t'(0));
    check("post_rst_ena", vec_t'(ena), vec_t'(0));

    // Shadow was cleared by reset, so only group 3 appears.
    host_write(7'h03, 16'h03C3, 1'b0);
    host_write(7'h40, 16'h00FF, 1'b0);
    do_commit();
    fw_exp = '0; fw_exp[3*FW +: FW] = 10'h3C3;
    apply_check(fw_exp, 72'h0, 72'h0000_00FF);

    // Clock-enable freeze during MUTE and across the done pulse.
    host_write(7'h03, 16'h00C3, 1'b0);
    do_commit();
    fw_exp = fw_model; fw_exp[3*FW +: FW] = 10'h0C3;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("ce_mute", vec_t'(ena), vec_t'(72'h0000_003F));
    tick();
    ce_1 = 1'b0; wr_en = 1'b1; wr_addr = 7'h30; frame_sync = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("ce_frz_ena", vec_t'(ena), vec_t'(72'h0000_003F));
    check("ce_frz_fw", freq_word, fw_model);
    check("ce_frz_busy", vec_t'(commit_busy), vec_t'(1'b1));
    check("ce_frz_err", vec_t'(wr_err), vec_t'(1'b0));
    ce_1 = 1'b1; wr_en = 1'b0; frame_sync = 1'b0;
    tick(); tick();
    check("ce_fw_hold", freq_word, fw_model);
    tick();
    check("ce_fw_swap", freq_word, fw_exp);
    tick();
    check("ce_ena_restore", vec_t'(ena), vec_t'(72'h0000_00FF));
    check("ce_done", vec_t'(commit_done), vec_t'(1'b1));
    check("ce_busy_clear", vec_t'(commit_busy), vec_t'(1'b0));
    ce_1 = 1'b0;
    tick(); tick(); tick();
    check("ce_done_frozen", vec_t'(commit_done), vec_t'(1'b1));
    ce_1 = 1'b1;
    tick();
    check("ce_done_clear", vec_t'(commit_done), vec_t'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
